mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shared-memory controller that lets up to four word-wide clients take turns on the single synchronous `Memory` block. Each transaction is sequenced through a fixed-latency state machine. Grants are round-robin, so no requester starves. The block sits between the client-side request logic and `Memory`, and drives `CS`, `WE`, `ADDR` and the bidirectional `Mem_Bus`.

## Interface
- `NCLI`, 4: number of clients. Legal values are 2..4.
- `AW`, 32: address width.
- `DW`, 32: data width.
- `MEM_WORDS`, 128: number of implemented memory words. Any address `>= MEM_WORDS` is out of range.

- `clk`  in  1  system clock. All state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  NCLI  per-client request level. Held by the client until it sees its `done` bit.
- `wr`  in  NCLI  per-client direction: 1 = write, 0 = read.
- `addr`  in  NCLI*AW  flattened word addresses. Client k uses bits `[k*AW +: AW]`.
- `wdata`  in  NCLI*DW  flattened write data, same packing as `addr`.
- `gnt`  out  NCLI  one-hot owner of the current transaction.
- `done`  out  NCLI  one-hot, one-cycle completion pulse.
- `err`  out  1  valid with `done`. 1 = address was out of range and memory was not accessed.
- `rdata`  out  DW  read data. Shared by all clients and valid while `done` is high for a read.
- `cs`  out  1  memory chip select.
- `we`  out  1  memory write enable.
- `mem_addr`  out  AW  memory address.
- `mem_bus`  inout  DW  memory data bus. Driven by this block only during write access. Otherwise `'z`.

## Operation
- States are `IDLE`, `ACCESS`, `RDWAIT`, `FINISH`.
- **IDLE**
  - If any `req` bit is set, pick the winner: the first set bit at or after pointer `ptr`, scanning upward and wrapping at `NCLI-1`.
  - Latch the winner's `wr`, `addr` and `wdata`, and set `gnt`.
  - If the address is in range, go to ACCESS. If it is out of range, set the error flag and go straight to FINISH.
- **ACCESS**
  - Outputs: `cs=1`, `we=wr_l`, `mem_addr=addr_l`.
  - For a write, `mem_bus` carries `wdata_l`. The next state is FINISH.
  - For a read, the bus is `'z` and the next state is RDWAIT.
- **RDWAIT**
  - Outputs: `cs=1`, `we=0`, `mem_addr` held.
  - At the end of the cycle, `rdata <= mem_bus`. The next state is FINISH.
- **FINISH**
  - Outputs: `done[owner]=1`, `err=err_l`, `cs=0`.
  - Set `ptr <= owner+1`, wrapping to 0 at `NCLI`.
  - Clear `gnt`. The next state is IDLE.
- **Latched values:** once the request is latched, later changes to `req`, `wr`, `addr` or `wdata` are ignored. Dropping `req` mid-transaction does not abort it.
- **Back-to-back requests:** if a client keeps `req` high after `done`, it is re-arbitrated in IDLE. Because `ptr` has advanced, any other pending client wins first.
- **Read data hold:** `rdata` holds its last captured value until the next read completes. Writes and error completions leave it unchanged.
- **Address range check:** the full AW-bit address is compared against `MEM_WORDS`. It is not truncated.

## Timing
- **Reset values:** state=IDLE, `ptr=0`, `gnt=0`, `done=0`, `err=0`, `rdata=0`, `cs=0`, `we=0`, `mem_addr=0`, `mem_bus='z`.
- **Reset mid-transaction:** abandon immediately. No `done` is issued. A write in ACCESS may or may not have reached memory, and the client must reissue it.
- **Latency**, from the edge that samples `req` in IDLE (edge E) to the `done` cycle:
  - Write: ACCESS after E, FINISH after E+1, so `done` is high during E+1..E+2. That is 2 cycles.
  - Read: ACCESS, RDWAIT, FINISH, so `done` is high during E+2..E+3. That is 3 cycles.
  - Error: FINISH directly, so `done` is high during E..E+1. That is 1 cycle.
- **Idle cycle:** exactly one IDLE cycle separates consecutive transactions. Peak rates are one write per 3 cycles and one read per 4 cycles.
- **Bus turnaround:** `mem_bus` is driven only in ACCESS with `wr_l=1`. The cycle before and the cycle after that are `'z`, so there is never contention with memory read drive.
- **Memory contract:**
  - A write commits on the rising edge that ends ACCESS.
  - For a read, memory drives `Mem_Bus` from the first edge inside ACCESS. Data is stable by the RDWAIT capture edge.
- **Simultaneous requests:** exactly one grant per arbitration. There are no ties, because scan order from `ptr` is strict.
- **Output hygiene:** `done` and `gnt` are never multi-hot. `done` is never high for two consecutive cycles.

## Test plan
- **Single read.** Reset, then client 0 reads addr 5 (memory preloaded with 5 -> `0x1234ABCD`). Expect `done[0]` 3 cycles after sampling, `rdata=0x1234ABCD`, `err=0`.
- **Write then read.** Client 2 writes `0xDEADBEEF` to addr 127, then reads addr 127. Expect `done` 2 and 3 cycles after sampling respectively, and `rdata=0xDEADBEEF`. `mem_bus` is `'z` in every cycle except the write ACCESS cycle.
- **Round-robin fairness.** All four clients hold `req` continuously with reads. Expect grant order 0,1,2,3,0,1…, with no client granted twice before every other pending client is granted.
- **Out-of-range address.** Client 1 reads addr 128. Expect `done[1]` and `err=1` one cycle after sampling, `cs` never asserted, and `rdata` unchanged.
- **Reset mid-read.** Assert `reset` asynchronously during RDWAIT. Expect every output at its reset value immediately with no `done` pulse. After release, the first request is arbitrated from `ptr=0`.
- **Randomized cross-check.** Run 512 random reads and writes across 4 clients against a bench reference memory model. Expect zero data mismatches and every issued request to receive exactly one `done`.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter that lets NCLI clients share one synchronous
// memory. Each transaction is latched in IDLE and then sequenced with a fixed
// latency: writes take 2 cycles, reads 3, and out-of-range addresses 1.
//
// state  | meaning
// IDLE   | pick a winner from ptr, latch its request, range-check the address
// ACCESS | cs asserted; a write drives mem_bus, a read lets memory drive it
// RDWAIT | cs held, capture mem_bus into rdata at the end of the cycle
// FINISH | one-cycle done pulse to the owner, advance ptr, release gnt
module mem_arbiter #(
  parameter int NCLI      = 4,
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MEM_WORDS = 128
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NCLI-1:0]    req,
  input  logic [NCLI-1:0]    wr,
  input  logic [NCLI*AW-1:0] addr,
  input  logic [NCLI*DW-1:0] wdata,
  output logic [NCLI-1:0]    gnt,
  output logic [NCLI-1:0]    done,
  output logic               err,
  output logic [DW-1:0]      rdata,
  output logic               cs,
  output logic               we,
  output logic [AW-1:0]      mem_addr,
  inout  wire logic [DW-1:0] mem_bus
);

  localparam int PW = (NCLI > 1) ? $clog2(NCLI) : 1;
  localparam logic [AW-1:0] LIMIT = AW'(MEM_WORDS);
  localparam logic [NCLI-1:0] ONE = NCLI'(1);

  typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT, FINISH} state_t;

  state_t          state, state_nx;
  logic [PW-1:0]   ptr, owner, win;
  logic            any_req, win_oor;
  logic            wr_l, err_l;
  logic [AW-1:0]   addr_l, win_addr;
  logic [DW-1:0]   wdata_l, win_wdata;
  int              idx;

  // Winner search: scan offsets downward so the smallest offset from ptr wins.
  always_comb begin
    win     = ptr;
    any_req = 1'b0;
    idx     = 0;
    for (int i = NCLI - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= NCLI) idx = idx - NCLI;
      if (req[idx]) begin
        win     = PW'(idx);
        any_req = 1'b1;
      end
    end
  end

  assign win_addr  = addr[int'(win)*AW +: AW];
  assign win_wdata = wdata[int'(win)*DW +: DW];
  // Full-width compare so large addresses never alias into the array.
  assign win_oor   = (win_addr >= LIMIT);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state sequencing; out-of-range requests skip the memory entirely.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any_req) state_nx = win_oor ? FINISH : ACCESS;
      ACCESS:  state_nx = wr_l ? FINISH : RDWAIT;
      RDWAIT:  state_nx = FINISH;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Memory-side and completion outputs decoded from the current state.
  always_comb begin
    cs       = (state == ACCESS) || (state == RDWAIT);
    we       = (state == ACCESS) && wr_l;
    done     = (state == FINISH) ? gnt : '0;
    err      = (state == FINISH) && err_l;
    mem_addr = addr_l;
  end

  // The bus is driven only in a write ACCESS cycle, so it is released on
  // both neighbouring cycles and never fights the memory's read drive.
  assign mem_bus = ((state == ACCESS) && wr_l) ? wdata_l : 'z;

  // Request latch, grant, read capture and round-robin pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr     <= '0;
      owner   <= '0;
      gnt     <= '0;
      wr_l    <= 1'b0;
      err_l   <= 1'b0;
      addr_l  <= '0;
      wdata_l <= '0;
      rdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner   <= win;
            gnt     <= ONE << win;
            wr_l    <= wr[win];
            addr_l  <= win_addr;
            wdata_l <= win_wdata;
            err_l   <= win_oor;
          end
        end
        RDWAIT: rdata <= mem_bus;
        FINISH: begin
          gnt <= '0;
          ptr <= (owner == PW'(NCLI - 1)) ? '0 : owner + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, round-robin and reset-abort
// sequences, then a randomized run against a transaction-level reference.
module tb_mem_arbiter;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    req, wr;
  logic [127:0]  addr, wdata;
  logic [3:0]    gnt, done;
  logic          err;
  logic [31:0]   rdata;
  logic          cs, we;
  logic [31:0]   mem_addr;
  wire  [31:0]   mem_bus;

  mem_arbiter #(.NCLI(4), .AW(32), .DW(32), .MEM_WORDS(128)) dut (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
    .gnt(gnt), .done(done), .err(err), .rdata(rdata), .cs(cs), .we(we),
    .mem_addr(mem_addr), .mem_bus(mem_bus)
  );

  always #5 clk = ~clk;

  // Synchronous memory the arbiter talks to.
  logic [31:0] mem [0:127];
  logic        mem_oe = 1'b0;
  logic [31:0] mem_q  = '0;
  logic        init_mem = 1'b0;

  function automatic logic [31:0] pat(input int i);
    return (i == 5) ? 32'h1234ABCD : (32'hA000_0000 ^ (32'(i) * 32'h0001_0203));
  endfunction

  assign mem_bus = mem_oe ? mem_q : 'z;

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 128; i++) mem[i] <= pat(i);
      mem_oe <= 1'b0;
    end else begin
      if (cs && we) mem[mem_addr[6:0]] <= mem_bus;
      mem_oe <= cs && !we;
      mem_q  <= mem[mem_addr[6:0]];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_client(input int c, input logic r, input logic w,
                            input logic [31:0] a, input logic [31:0] d);
    req[c] = r;
    wr[c]  = w;
    addr[c*32 +: 32]  = a;
    wdata[c*32 +: 32] = d;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    init_mem = 1'b1;
    req = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    init_mem = 1'b0;
  endtask

  // One transaction from a lone requester; returns what the done cycle showed.
  task automatic run_txn(input int c, input logic w, input logic [31:0] a, input logic [31:0] d,
                         output int lat, output logic [3:0] dn, output logic e,
                         output logic [31:0] rd, output logic [3:0] g, output logic saw_cs);
    @(negedge clk);
    set_client(c, 1'b1, w, a, d);
    lat = 0; dn = '0; e = 1'b0; rd = '0; g = '0; saw_cs = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      lat++;
      if (cs) saw_cs = 1'b1;
      if (cs) chk("mem_addr in access", mem_addr, a);
      if (we) chk("write bus data", mem_bus, d);
      if (done != 0) begin
        dn = done; e = err; rd = rdata; g = gnt;
        break;
      end
    end
    req[c] = 1'b0;
  endtask

  typedef struct {
    int          cli;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    int          lat;
    logic        e;
    logic [31:0] rd;
  } vec_t;

  // Transaction-level reference state for the randomized run.
  logic [31:0] ref_mem [0:127];
  bit          m_act;
  int          m_rem, m_own, m_ptr;
  logic        m_w, m_e;
  logic [31:0] m_a, m_rdv, m_rdata;
  logic        c_w [4];
  logic [31:0] c_a [4], c_d [4];
  int          ops_left [4], wait_c [4], issued [4], done_cnt [4];
  int          total_done;

  task automatic new_op(input int c);
    c_w[c] = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 15) == 0) c_a[c] = 32'd128 + $urandom_range(0, 5000);
    else if ($urandom_range(0, 31) == 0) c_a[c] = 32'hFFFF_FF80 | 32'($urandom_range(0, 127));
    else c_a[c] = 32'($urandom_range(0, 127));
    c_d[c] = $urandom;
    set_client(c, 1'b1, c_w[c], c_a[c], c_d[c]);
    issued[c]++;
    ops_left[c]--;
  endtask

  // Advance the reference by one clock edge using the inputs that edge saw.
  task automatic model_edge();
    int c;
    if (m_act) begin
      if (m_rem == 0) begin
        m_act = 1'b0;
        m_ptr = (m_own + 1) % 4;
      end else begin
        m_rem--;
        if (m_rem == 0 && !m_w && !m_e) m_rdata = m_rdv;
      end
    end else if (req != 0) begin
      for (int i = 0; i < 4; i++) begin
        c = (m_ptr + i) % 4;
        if (req[c]) begin
          m_own = c;
          break;
        end
      end
      m_act = 1'b1;
      m_w = c_w[m_own];
      m_a = c_a[m_own];
      m_e = (m_a >= 32'd128);
      m_rem = m_e ? 0 : (m_w ? 1 : 2);
      if (!m_e && m_w)  ref_mem[m_a[6:0]] = c_d[m_own];
      if (!m_e && !m_w) m_rdv = ref_mem[m_a[6:0]];
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vt [8];
    int          lat, k, cyc;
    logic [3:0]  dn, g, e_gnt, e_done;
    logic        e, saw_cs, e_err, e_cs, e_we;
    logic [31:0] rd;

    vt[0] = '{0, 1'b0, 32'd5,          32'h0,         3, 1'b0, 32'h1234ABCD};
    vt[1] = '{2, 1'b1, 32'd127,        32'hDEADBEEF,  2, 1'b0, 32'h1234ABCD};
    vt[2] = '{2, 1'b0, 32'd127,        32'h0,         3, 1'b0, 32'hDEADBEEF};
    vt[3] = '{1, 1'b0, 32'd128,        32'h0,         1, 1'b1, 32'hDEADBEEF};
    vt[4] = '{3, 1'b1, 32'h8000_0005,  32'h5555_5555, 1, 1'b1, 32'hDEADBEEF};
    vt[5] = '{3, 1'b0, 32'd5,          32'h0,         3, 1'b0, 32'h1234ABCD};
    vt[6] = '{1, 1'b1, 32'd0,          32'h0000_00A5, 2, 1'b0, 32'h1234ABCD};
    vt[7] = '{0, 1'b0, 32'd0,          32'h0,         3, 1'b0, 32'h0000_00A5};

    req = '0; wr = '0; addr = '0; wdata = '0;
    reset = 1'b1;
    init_mem = 1'b1;
    #1;
    chk("reset gnt", gnt, 0);
    chk("reset done", done, 0);
    chk("reset err", err, 0);
    chk("reset rdata", rdata, 0);
    chk("reset cs", cs, 0);
    chk("reset we", we, 0);
    chk("reset mem_addr", mem_addr, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    init_mem = 1'b0;

    // Directed single-requester table.
    for (int v = 0; v < 8; v++) begin
      run_txn(vt[v].cli, vt[v].w, vt[v].a, vt[v].d, lat, dn, e, rd, g, saw_cs);
      chk($sformatf("vec%0d latency", v), lat, vt[v].lat);
      chk($sformatf("vec%0d done", v), dn, 4'b1 << vt[v].cli);
      chk($sformatf("vec%0d gnt", v), g, 4'b1 << vt[v].cli);
      chk($sformatf("vec%0d err", v), e, vt[v].e);
      chk($sformatf("vec%0d rdata", v), rd, vt[v].rd);
      if (vt[v].e) chk($sformatf("vec%0d cs during err", v), saw_cs, 0);
    end

    // Round-robin: all four clients read continuously from ptr=0.
    do_reset();
    for (int c = 0; c < 4; c++) set_client(c, 1'b1, 1'b0, 32'(c + 1), 32'h0);
    k = 0;
    for (int n = 0; n < 60 && k < 8; n++) begin
      @(negedge clk);
      if (done != 0) begin
        chk($sformatf("rr grant %0d", k), done, 4'b1 << (k % 4));
        chk($sformatf("rr rdata %0d", k), rdata, pat((k % 4) + 1));
        k++;
      end
    end
    chk("rr completions", k, 8);
    req = '0;
    @(negedge clk);
    @(negedge clk);

    // Reset during RDWAIT; afterwards arbitration restarts from client 0.
    run_txn(1, 1'b0, 32'd7, 32'h0, lat, dn, e, rd, g, saw_cs);
    chk("pre-abort read", rd, pat(7));
    @(negedge clk);
    set_client(2, 1'b1, 1'b0, 32'd9, 32'h0);
    @(negedge clk);
    chk("abort access cs", cs, 1);
    @(negedge clk);
    chk("abort rdwait cs", cs, 1);
    chk("abort rdwait we", we, 0);
    #2 reset = 1'b1;
    #1;
    chk("abort gnt", gnt, 0);
    chk("abort done", done, 0);
    chk("abort err", err, 0);
    chk("abort rdata", rdata, 0);
    chk("abort cs", cs, 0);
    chk("abort we", we, 0);
    chk("abort mem_addr", mem_addr, 0);
    req[2] = 1'b0;
    @(negedge clk);
    chk("abort no done", done, 0);
    set_client(0, 1'b1, 1'b0, 32'd3, 32'h0);
    set_client(3, 1'b1, 1'b0, 32'd4, 32'h0);
    reset = 1'b0;
    dn = '0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (done != 0) begin
        dn = done;
        rd = rdata;
        break;
      end
    end
    chk("post-abort first winner", dn, 4'b0001);
    chk("post-abort rdata", rd, pat(3));
    req = '0;
    @(negedge clk);
    @(negedge clk);

    // Randomized run against the reference.
    do_reset();
    for (int i = 0; i < 128; i++) ref_mem[i] = pat(i);
    m_act = 1'b0; m_ptr = 0; m_rem = 0; m_own = 0; m_rdata = '0; m_rdv = '0;
    m_w = 1'b0; m_e = 1'b0; m_a = '0;
    total_done = 0;
    for (int c = 0; c < 4; c++) begin
      ops_left[c] = 128; wait_c[c] = c; issued[c] = 0; done_cnt[c] = 0;
      c_w[c] = 1'b0; c_a[c] = '0; c_d[c] = '0;
    end
    cyc = 0;
    while (total_done < 512 && cyc < 20000) begin
      @(posedge clk);
      #1;
      model_edge();
      @(negedge clk);
      cyc++;
      e_gnt  = m_act ? (4'b1 << m_own) : 4'b0;
      e_done = (m_act && m_rem == 0) ? e_gnt : 4'b0;
      e_err  = m_act && m_rem == 0 && m_e;
      e_cs   = m_act && m_rem > 0;
      e_we   = e_cs && m_w && m_rem == 1;
      chk("rand gnt", gnt, e_gnt);
      chk("rand done", done, e_done);
      chk("rand err", err, e_err);
      chk("rand cs", cs, e_cs);
      chk("rand we", we, e_we);
      chk("rand rdata", rdata, m_rdata);
      if (e_cs) chk("rand mem_addr", mem_addr, m_a);
      if (e_we) chk("rand bus data", mem_bus, c_d[m_own]);
      for (int c = 0; c < 4; c++) begin
        if (done[c]) done_cnt[c]++;
        if (req[c] && e_done[c]) begin
          req[c] = 1'b0;
          total_done++;
          if (ops_left[c] > 0 && $urandom_range(0, 2) == 0) new_op(c);
          else wait_c[c] = $urandom_range(0, 2);
        end else if (!req[c] && ops_left[c] > 0) begin
          if (wait_c[c] == 0) new_op(c);
          else wait_c[c]--;
        end
      end
    end
    chk("rand all completed", total_done, 512);
    for (int c = 0; c < 4; c++)
      chk($sformatf("rand done count c%0d", c), done_cnt[c], issued[c]);
    req = '0;
    @(negedge clk);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
